// File: rtl/battle_pkg.sv
// battle_pkg: shared types for the battle screen sequencer.
//   battle_state_t : turn-level state, encodings are visible on state_out
//   anim_phase_t   : game-over animation phase (whole / divided / falling / done)
//   rgb444_t       : 12-bit pixel, {R[3:0], G[3:0], B[3:0]}
//   sat_add444     : per-channel saturating add of two RGB444 pixels
package battle_pkg;

   typedef enum logic [3:0] {
      ST_MENU    = 4'b0000,
      ST_PLAYER  = 4'b0001,
      ST_ENEMY   = 4'b1000,
      ST_VICTORY = 4'b0100,
      ST_OVER    = 4'b1111
   } battle_state_t;

   typedef enum logic [1:0] {
      PH_HOLD  = 2'd0,
      PH_SPLIT = 2'd1,
      PH_FALL  = 2'd2,
      PH_DONE  = 2'd3
   } anim_phase_t;

   typedef logic [11:0] rgb444_t;

   // Each 4-bit channel is summed in 5 bits; a carry clamps it to 0xF.
   function automatic rgb444_t sat_add444(input rgb444_t a, input rgb444_t b);
      rgb444_t    r;
      logic [4:0] s;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         s = {1'b0, a[c*4 +: 4]} + {1'b0, b[c*4 +: 4]};
         r[c*4 +: 4] = s[4] ? 4'hF : s[3:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det: one-bit rising-edge detector.
//   clk, rst : clock, synchronous active-high reset (history clears to 0)
//   d_in     : level to watch
//   rise_out : high in the cycle d_in is 1 and was 0 the cycle before
// The history register samples every cycle unconditionally, so a level that
// rises while the consumer is not listening is never seen as an edge later.
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise_out
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = d_in;
   end

   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= prev_d;
   end

   assign rise_out = d_in & ~prev_q;

endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: turn sequencer and layer compositor for the battle screen.
//   Steps MENU -> PLAYER -> ENEMY -> MENU on done edges, counts completed
//   enemy turns, ends in VICTORY after NUM_ROUNDS or in OVER on a game_over
//   edge, where a timed three-phase heart animation plays out.
// Ports:
//   clk, rst                     : pixel clock, synchronous active-high reset
//   menu/player/enemy_done_in    : turn-finished levels (rising edge = event)
//   game_over_in                 : HP reached zero (rising edge = event)
//   restart_in                   : restart request, VICTORY or OVER phase 3
//   pause_in                     : freeze request (BATTLE_SEQ_PAUSE_EN only)
//   *_pix_in                     : RGB444 layer pixels
//   state_out, round_out         : current state, completed enemy turns
//   round_rst_out                : one-cycle pulse resetting turn sub-blocks
//   anim_phase_out, divided_out, fall_valid_out, over_done_out : animation
//   pixel_out                    : registered composited pixel
// Build option: define BATTLE_SEQ_PAUSE_EN to add pause_in.
module battle_sequencer
   import battle_pkg::*;
#(
   parameter int NUM_ROUNDS   = 8,
   parameter int HOLD_CYCLES  = 65_000_000,
   parameter int SPLIT_CYCLES = 130_000_000,
   parameter int FALL_CYCLES  = 195_000_000,
   parameter int RW           = $clog2(NUM_ROUNDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          menu_done_in,
   input  logic          player_done_in,
   input  logic          enemy_done_in,
   input  logic          game_over_in,
   input  logic          restart_in,
`ifdef BATTLE_SEQ_PAUSE_EN
   input  logic          pause_in,
`endif
   input  logic [11:0]   menu_pix_in,
   input  logic [11:0]   player_pix_in,
   input  logic [11:0]   enemy_pix_in,
   input  logic [11:0]   hud_pix_in,
   input  logic [11:0]   heart_pix_in,
   input  logic [11:0]   fall_pix_in,
   input  logic [11:0]   text_pix_in,
   output logic [3:0]    state_out,
   output logic [RW-1:0] round_out,
   output logic          round_rst_out,
   output logic [1:0]    anim_phase_out,
   output logic          divided_out,
   output logic          fall_valid_out,
   output logic          over_done_out,
   output logic [11:0]   pixel_out
);

   localparam logic [31:0]   HOLD_LAST   = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0]   SPLIT_LAST  = 32'(SPLIT_CYCLES - 1);
   localparam logic [31:0]   FALL_LAST   = 32'(FALL_CYCLES - 1);
   localparam logic [RW-1:0] ROUND_LIMIT = RW'(NUM_ROUNDS);

   // ---------------------------------------------------------------- edges
   logic menu_rise, player_rise, enemy_rise, over_rise, restart_rise;

   edge_det u_menu_edge    (.clk(clk), .rst(rst), .d_in(menu_done_in),   .rise_out(menu_rise));
   edge_det u_player_edge  (.clk(clk), .rst(rst), .d_in(player_done_in), .rise_out(player_rise));
   edge_det u_enemy_edge   (.clk(clk), .rst(rst), .d_in(enemy_done_in),  .rise_out(enemy_rise));
   edge_det u_over_edge    (.clk(clk), .rst(rst), .d_in(game_over_in),   .rise_out(over_rise));
   edge_det u_restart_edge (.clk(clk), .rst(rst), .d_in(restart_in),     .rise_out(restart_rise));

   logic freeze;
`ifdef BATTLE_SEQ_PAUSE_EN
   assign freeze = pause_in;
`else
   assign freeze = 1'b0;
`endif

   // ---------------------------------------------------------------- state
   battle_state_t state_q, state_d;
   anim_phase_t   phase_q, phase_d;
   logic [RW-1:0] round_q, round_d;
   logic          round_rst_q, round_rst_d;
   logic [31:0]   timer_q, timer_d;
   rgb444_t       pixel_q, pixel_d;

   logic [RW-1:0] round_inc;
   assign round_inc = round_q + RW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_MENU;
         phase_q     <= PH_HOLD;
         round_q     <= '0;
         round_rst_q <= 1'b0;
         timer_q     <= '0;
         pixel_q     <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         round_q     <= round_d;
         round_rst_q <= round_rst_d;
         timer_q     <= timer_d;
         pixel_q     <= pixel_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      round_d     = round_q;
      round_rst_d = 1'b0;
      timer_d     = timer_q;

      // A frozen sequencer drops every event; edge history still advances.
      if (!freeze) begin
         unique case (state_q)
            ST_MENU, ST_PLAYER, ST_ENEMY: begin
               // game_over beats any simultaneous done edge.
               if (over_rise) begin
                  state_d = ST_OVER;
                  phase_d = PH_HOLD;
                  timer_d = '0;
               end else if (state_q == ST_MENU && menu_rise) begin
                  state_d = ST_PLAYER;
               end else if (state_q == ST_PLAYER && player_rise) begin
                  state_d = ST_ENEMY;
               end else if (state_q == ST_ENEMY && enemy_rise) begin
                  round_d     = round_inc;
                  round_rst_d = 1'b1;
                  state_d     = (round_inc == ROUND_LIMIT) ? ST_VICTORY : ST_MENU;
               end
            end
            ST_VICTORY: begin
               if (restart_rise) begin
                  state_d     = ST_MENU;
                  round_d     = '0;
                  phase_d     = PH_HOLD;
                  timer_d     = '0;
                  round_rst_d = 1'b1;
               end
            end
            ST_OVER: begin
               if (restart_rise && phase_q == PH_DONE) begin
                  state_d     = ST_MENU;
                  round_d     = '0;
                  phase_d     = PH_HOLD;
                  timer_d     = '0;
                  round_rst_d = 1'b1;
               end else begin
                  unique case (phase_q)
                     PH_HOLD: begin
                        if (timer_q == HOLD_LAST) begin
                           phase_d = PH_SPLIT;
                           timer_d = '0;
                        end else timer_d = timer_q + 32'd1;
                     end
                     PH_SPLIT: begin
                        if (timer_q == SPLIT_LAST) begin
                           phase_d = PH_FALL;
                           timer_d = '0;
                        end else timer_d = timer_q + 32'd1;
                     end
                     PH_FALL: begin
                        if (timer_q == FALL_LAST) begin
                           phase_d = PH_DONE;
                           timer_d = '0;
                        end else timer_d = timer_q + 32'd1;
                     end
                     default: timer_d = timer_q;
                  endcase
               end
            end
            default: state_d = ST_MENU;
         endcase
      end
   end

   // ------------------------------------------------------------ compositor
   // Layer selection follows the registered state, so the pixel trails the
   // state/phase by one cycle, same as it trails the layer inputs.
   always_comb begin
      pixel_d = '0;
      unique case (state_q)
         ST_MENU:    pixel_d = sat_add444(menu_pix_in,   hud_pix_in);
         ST_PLAYER:  pixel_d = sat_add444(player_pix_in, hud_pix_in);
         ST_ENEMY:   pixel_d = sat_add444(enemy_pix_in,  hud_pix_in);
         ST_VICTORY: pixel_d = sat_add444(hud_pix_in,    text_pix_in);
         ST_OVER: begin
            if (phase_q == PH_HOLD || phase_q == PH_SPLIT)
               pixel_d = sat_add444(heart_pix_in, text_pix_in);
            else
               pixel_d = sat_add444(fall_pix_in, text_pix_in);
         end
         default:    pixel_d = '0;
      endcase
   end

   // --------------------------------------------------------------- outputs
   assign state_out      = state_q;
   assign round_out      = round_q;
   assign round_rst_out  = round_rst_q;
   assign anim_phase_out = phase_q;
   assign divided_out    = (phase_q != PH_HOLD);
   assign fall_valid_out = (phase_q == PH_FALL) || (phase_q == PH_DONE);
   assign over_done_out  = (phase_q == PH_DONE);
   assign pixel_out      = pixel_q;

endmodule

// File: doc/battle_sequencer.md
# battle_sequencer

Top-level turn sequencer for the battle screen: steps through menu, player and enemy turns, counts rounds, and ends in either victory or a timed game-over animation. Also composites the active layers into one 12-bit pixel. It replaces the fixed-encoding state logic that sat beside the enemy/menu/player instances, and adds rising-edge-correct handshakes, a parametrised round limit, a victory state and a restart path.

## Interface
- NUM_ROUNDS, 8: enemy turns survived before VICTORY (≥1)
- HOLD_CYCLES, 65_000_000: game-over phase 0 length, whole heart
- SPLIT_CYCLES, 130_000_000: phase 1 length, divided heart
- FALL_CYCLES, 195_000_000: phase 2 length, heart falling apart
- RW, $clog2(NUM_ROUNDS+1): round counter width
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- menu_done_in, player_done_in, enemy_done_in  in  1 each  turn-finished levels
- game_over_in  in  1  HP reached zero
- restart_in  in  1  restart request, honoured only in OVER and VICTORY
- pause_in  in  1  freeze request; present only with BATTLE_SEQ_PAUSE_EN
- menu_pix_in, player_pix_in, enemy_pix_in, hud_pix_in, heart_pix_in, fall_pix_in, text_pix_in  in  12 each  layer pixels, RGB444
- state_out  out  4  MENU=0000, PLAYER=0001, ENEMY=1000, VICTORY=0100, OVER=1111
- round_out  out  RW  completed enemy turns
- round_rst_out  out  1  one-cycle pulse that resets turn sub-blocks
- anim_phase_out  out  2  game-over phase 0..3
- divided_out, fall_valid_out, over_done_out  out  1  animation controls
- pixel_out  out  12  composited pixel, registered

## Operation
- Every event is a rising edge: `x && !x_prev`. The `*_prev` registers reset to 0 and sample every cycle, including cycles where round_rst_out is high.
- MENU goes to PLAYER on a menu_done edge.
- PLAYER goes to ENEMY on a player_done edge.
- ENEMY, on an enemy_done edge:
  - pulses round_rst_out and increments round_out;
  - goes to VICTORY if the new count equals NUM_ROUNDS, otherwise to MENU.
- A game_over edge in MENU, PLAYER or ENEMY goes to OVER. It takes priority over a simultaneous done edge: no round increment and no round_rst_out.
- Done edges that do not match the current state are ignored.
- In OVER, a 32-bit timer counts from 0:
  - phase 0 lasts HOLD_CYCLES, phase 1 lasts SPLIT_CYCLES, phase 2 lasts FALL_CYCLES, then phase 3 holds;
  - each phase transition occurs when the timer equals the phase length minus 1; the timer then clears.
- Animation outputs by phase:
  - divided_out = 1 in phases ≥1;
  - fall_valid_out = 1 in phases ≥2;
  - over_done_out = 1 in phase 3.
- Restart is accepted on a restart_in edge in VICTORY, or in OVER only when phase = 3. On acceptance: state goes to MENU, round_out = 0, anim phase and timer = 0, round_rst_out pulses.
- Further game_over edges in OVER or VICTORY are ignored.
- Compositing is a per-channel saturating 4-bit add of the selected layers:
  - MENU: menu + hud
  - PLAYER: player + hud
  - ENEMY: enemy + hud
  - VICTORY: hud + text
  - OVER phases 0–1: heart + text
  - OVER phases 2–3: fall + text
  - Example: 0xF80 + 0x0A0 = 0xFF0.

## Timing
- An edge on an input sampled at clock edge n changes state_out, round_out and round_rst_out at edge n; they are visible in cycle n+1. round_rst_out is high for exactly that one cycle.
- pixel_out has 1-cycle latency from the pixel inputs and from state_out/anim_phase_out.
- Reset values: state_out = MENU, round_out = 0, round_rst_out = 0, anim_phase_out = 0, divided_out = 0, fall_valid_out = 0, over_done_out = 0, pixel_out = 0, timer = 0.
- Reset mid-animation or mid-turn returns immediately to these values. round_rst_out is not pulsed by rst.

## Configuration
- BATTLE_SEQ_PAUSE_EN defined: pause_in exists. While it is high:
  - the state, round counter and OVER timer hold;
  - done, game_over and restart edges are discarded, with `*_prev` still updated;
  - pixel_out continues to update.
- Undefined: no pause_in port; the sequencer never freezes.

## Structure
- Package battle_pkg holds:
  - the state enum (battle_state_t) with the encodings above;
  - the anim phase enum;
  - the RGB444 type;
  - the function sat_add444.
- One sub-module, edge_det: a one-bit rising-edge detector with a synchronous reset, instantiated per handshake input.

## Test plan
Parameters for all tests: NUM_ROUNDS=2, HOLD=4, SPLIT=3, FALL=2.

- **Full round:** pulse menu, player and enemy done in turn. Expect state 0000→0001→1000→0000, round_out=1 and a single-cycle round_rst_out.
- **Victory:** complete two full rounds. Expect state_out=0100 and round_out=2. A restart edge then gives MENU, round_out=0 and a round_rst pulse.
- **Game over:** raise game_over in ENEMY together with enemy_done. Expect OVER, round_out unchanged and no round_rst. Phase 0 lasts 4 cycles, phase 1 lasts 3 with divided=1, phase 2 lasts 2 with fall_valid=1, then over_done=1.
- **Level and early-restart robustness:** hold menu_done high for 10 cycles and expect exactly one transition. A restart edge in OVER phase 1 must be ignored.
- **Compositing:** in PLAYER with player=0xF80, hud=0x0A0, expect pixel_out=0xFF0 one cycle later. In OVER phase 2, expect fall+text.
- **Pause (macro on):** holding pause in OVER phase 1 freezes the timer. A menu_done edge under pause is dropped. Reset mid-phase-2 restores all reset values.
